mips_mc_ctrl: RTL and testbench
===============================

MIPS_MC_CTRL -- requirements
Module: mips_mc_ctrl

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 clk  in  1  clock; all state changes on rising edge.
REQ-003 reset  in  1  asynchronous, active-high.
REQ-004 op  in  6  opcode from instruction register; stable from DECODE onward.
REQ-005 funct  in  6  funct field from instruction register.
REQ-006 zero  in  1  ALU result == 0, combinational from datapath.
REQ-007 mem_ready  in  1  unified memory completes the access this cycle.
REQ-008 pcen  out  1  PC write enable, including branch decision.
REQ-009 iord, irwrite, memwrite, regdst, memtoreg, regwrite, alusrca  out  1 each  datapath controls.
REQ-010 alusrcb  out  2  selects: 00 regB, 01 const 4, 10 signimm, 11 signimm<<2.
REQ-011 pcsrc  out  2  selects: 00 ALU result, 01 ALUOut, 10 jump target, 11 register A.
REQ-012 alucontrol  out  3  encodings: 010 add, 110 sub, 000 and, 001 or, 111 slt, 011 sll.
REQ-013 retire  out  1  one-cycle pulse on the final cycle of each instruction.
REQ-014 trap  out  1  sticky illegal-instruction flag.
REQ-015 state  out  4  current FSM state, for debug.

Function
REQ-016 The FSM SHALL use the states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, SLTIEX, IMMWB, JUMP, JR and TRAP.
REQ-017 Unlisted outputs in any state SHALL be 0, and alucontrol SHALL default to 010.
REQ-018 FETCH: iord=0, alusrca=0, alusrcb=01, pcsrc=00, irwrite=pcen=mem_ready; hold in FETCH while mem_ready=0, else go to DECODE.
REQ-019 DECODE: alusrca=0, alusrcb=11, add; next state by op:
  - 100011/101011 -> MEMADR
  - 000000 -> EXEC, or JR if funct=001000
  - 000100/000101 -> BRANCH
  - 001000 -> ADDIEX
  - 001010 -> SLTIEX
  - 000010 -> JUMP
  - else -> TRAP
REQ-020 MEMADR: alusrca=1, alusrcb=10, add; lw -> MEMRD, sw -> MEMWR.
REQ-021 MEMRD: iord=1; hold until mem_ready, then MEMWB.
REQ-022 MEMWR: iord=1, memwrite=1 held while waiting; on mem_ready, retire and go to FETCH.
REQ-023 MEMWB: regdst=0, memtoreg=1, regwrite=1, retire -> FETCH.
REQ-024 EXEC: alusrca=1, alusrcb=00, alucontrol from funct (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, 000000 sll) -> ALUWB; any other funct -> TRAP.
REQ-025 ALUWB: regdst=1, memtoreg=0, regwrite=1, retire -> FETCH.
REQ-026 ADDIEX/SLTIEX: alusrca=1, alusrcb=10, add/slt respectively -> IMMWB; IMMWB: regdst=0, regwrite=1, retire -> FETCH.
REQ-027 BRANCH: alusrca=1, alusrcb=00, sub, pcsrc=01; pcen=zero for op 000100, pcen=~zero for op 000101; retire -> FETCH.
REQ-028 JUMP: pcsrc=10, pcen=1, retire -> FETCH.
REQ-029 JR: pcsrc=11, pcen=1, retire -> FETCH.
REQ-030 TRAP: all enables 0, trap=1; the FSM stays in TRAP until reset.
REQ-031 With mem_ready held at 1, latency SHALL be: lw 5 cycles; sw, R-type, addi and slti 4; beq, bne, j and jr 3. Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds exactly one cycle.
REQ-032 All outputs SHALL be combinational from state, op, funct, zero and mem_ready, with no registered outputs besides state.

Reset
REQ-033 Reset SHALL force state=FETCH immediately and clear trap.
REQ-034 While reset is high, pcen, irwrite, regwrite, memwrite and retire SHALL be 0.
REQ-035 Reset asserted mid-instruction, including during a memory wait, SHALL abandon the instruction with no write enable asserted afterward.

Structure
REQ-036 Package mips_mc_pkg SHALL hold the state enum, opcode and funct constants, and the alucontrol, alusrcb and pcsrc encodings.
REQ-037 One sub-module, mc_aludec, SHALL map funct to alucontrol plus a valid flag; the FSM SHALL be a single always_ff state register plus always_comb next-state/output logic.

Verification
REQ-038 lw with mem_ready=1: states FETCH,DECODE,MEMADR,MEMRD,MEMWB; regwrite=1 and memtoreg=1 only in cycle 5; retire pulses once.
REQ-039 sw with mem_ready low for 2 cycles in MEMWR: memwrite=1 for 3 consecutive cycles, retire in the 3rd, then FETCH.
REQ-040 bne with zero=0 -> pcen=1, pcsrc=01 in BRANCH; bne with zero=1 -> pcen=0; beq is the mirror case.
REQ-041 R-type funct=001000 -> DECODE then JR with pcsrc=11, pcen=1; funct=100111 -> TRAP, trap=1 stays set for 10+ cycles.
REQ-042 Reset pulse while in MEMRD -> state=0 (FETCH) asynchronously, no regwrite, trap=0.

Source files
------------

// File: rtl/mips_mc_ctrl_pkg.sv
// Shared constants for the multicycle MIPS controller.
// Holds the state codes, the opcode and funct values the controller
// decodes, and the alucontrol / alusrcb / pcsrc select encodings.
package mips_mc_pkg;

   typedef logic [3:0] state_t;

   localparam state_t S_FETCH  = 4'd0;
   localparam state_t S_DECODE = 4'd1;
   localparam state_t S_MEMADR = 4'd2;
   localparam state_t S_MEMRD  = 4'd3;
   localparam state_t S_MEMWB  = 4'd4;
   localparam state_t S_MEMWR  = 4'd5;
   localparam state_t S_EXEC   = 4'd6;
   localparam state_t S_ALUWB  = 4'd7;
   localparam state_t S_BRANCH = 4'd8;
   localparam state_t S_ADDIEX = 4'd9;
   localparam state_t S_SLTIEX = 4'd10;
   localparam state_t S_IMMWB  = 4'd11;
   localparam state_t S_JUMP   = 4'd12;
   localparam state_t S_JR     = 4'd13;
   localparam state_t S_TRAP   = 4'd14;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] F_ADD = 6'b100000;
   localparam logic [5:0] F_SUB = 6'b100010;
   localparam logic [5:0] F_AND = 6'b100100;
   localparam logic [5:0] F_OR  = 6'b100101;
   localparam logic [5:0] F_SLT = 6'b101010;
   localparam logic [5:0] F_SLL = 6'b000000;
   localparam logic [5:0] F_JR  = 6'b001000;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;
   localparam logic [2:0] ALU_SLL = 3'b011;

   localparam logic [1:0] SRCB_REGB  = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;
   localparam logic [1:0] PCSRC_REGA   = 2'b11;

endpackage

// File: rtl/mips_mc_ctrl_if.sv
// Controller <-> datapath bundle.
// master: controller side (takes op/funct/zero/mem_ready, drives controls).
// slave : datapath side (the reverse).
interface mips_mc_ctrl_if;
   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic       mem_ready;
   logic       pcen;
   logic       iord;
   logic       irwrite;
   logic       memwrite;
   logic       regdst;
   logic       memtoreg;
   logic       regwrite;
   logic       alusrca;
   logic [1:0] alusrcb;
   logic [1:0] pcsrc;
   logic [2:0] alucontrol;
   logic       retire;
   logic       trap;
   logic [3:0] state;

   modport master (
      input  op, funct, zero, mem_ready,
      output pcen, iord, irwrite, memwrite, regdst, memtoreg, regwrite,
             alusrca, alusrcb, pcsrc, alucontrol, retire, trap, state
   );

   modport slave (
      output op, funct, zero, mem_ready,
      input  pcen, iord, irwrite, memwrite, regdst, memtoreg, regwrite,
             alusrca, alusrcb, pcsrc, alucontrol, retire, trap, state
   );
endinterface

// File: rtl/mips_mc_ctrl_aludec.sv
// R-type funct to ALU operation decoder.
// Ports: funct (in, 6), alucontrol (out, 3), valid (out, 1: funct is supported).
module mc_aludec
   import mips_mc_pkg::*;
(
   input  logic [5:0] funct,
   output logic [2:0] alucontrol,
   output logic       valid
);

   always_comb begin
      alucontrol = ALU_ADD;
      valid      = 1'b1;
      case (funct)
         F_ADD:   alucontrol = ALU_ADD;
         F_SUB:   alucontrol = ALU_SUB;
         F_AND:   alucontrol = ALU_AND;
         F_OR:    alucontrol = ALU_OR;
         F_SLT:   alucontrol = ALU_SLT;
         F_SLL:   alucontrol = ALU_SLL;
         default: valid      = 1'b0;
      endcase
   end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM.
// Ports: clk, reset (async, active-high), bus (mips_mc_ctrl_if.master):
//   in  op, funct, zero, mem_ready
//   out pcen, iord, irwrite, memwrite, regdst, memtoreg, regwrite, alusrca,
//       alusrcb, pcsrc, alucontrol, retire, trap, state
//
// state  | meaning
// FETCH  | read instruction, PC+4; wait for memory
// DECODE | register read, branch target into ALUOut
// MEMADR | compute load/store address
// MEMRD  | load data read; wait for memory
// MEMWB  | write load data to rt
// MEMWR  | store; memwrite held until memory completes
// EXEC   | R-type ALU operation
// ALUWB  | write ALU result to rd
// BRANCH | compare, conditional PC update
// ADDIEX | addi ALU operation
// SLTIEX | slti ALU operation
// IMMWB  | write immediate-op result to rt
// JUMP   | PC <- jump target
// JR     | PC <- register A
// TRAP   | illegal instruction; parked until reset
module mips_mc_ctrl
   import mips_mc_pkg::*;
(
   input  logic clk,
   input  logic reset,
   mips_mc_ctrl_if.master bus
);

   state_t     state_q, state_nxt;
   logic [2:0] aludec_ctrl;
   logic       aludec_valid;

   mc_aludec u_aludec (
      .funct      (bus.funct),
      .alucontrol (aludec_ctrl),
      .valid      (aludec_valid)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_nxt;
   end

   always_comb begin
      state_nxt      = state_q;
      bus.pcen       = 1'b0;
      bus.iord       = 1'b0;
      bus.irwrite    = 1'b0;
      bus.memwrite   = 1'b0;
      bus.regdst     = 1'b0;
      bus.memtoreg   = 1'b0;
      bus.regwrite   = 1'b0;
      bus.alusrca    = 1'b0;
      bus.alusrcb    = SRCB_REGB;
      bus.pcsrc      = PCSRC_ALU;
      bus.alucontrol = ALU_ADD;
      bus.retire     = 1'b0;
      bus.trap       = 1'b0;
      case (state_q)
         S_FETCH: begin
            bus.alusrcb = SRCB_FOUR;
            bus.irwrite = bus.mem_ready;
            bus.pcen    = bus.mem_ready;
            if (bus.mem_ready) state_nxt = S_DECODE;
         end
         S_DECODE: begin
            bus.alusrcb = SRCB_IMMSH;
            case (bus.op)
               OP_LW, OP_SW:   state_nxt = S_MEMADR;
               OP_RTYPE:       state_nxt = (bus.funct == F_JR) ? S_JR : S_EXEC;
               OP_BEQ, OP_BNE: state_nxt = S_BRANCH;
               OP_ADDI:        state_nxt = S_ADDIEX;
               OP_SLTI:        state_nxt = S_SLTIEX;
               OP_J:           state_nxt = S_JUMP;
               default:        state_nxt = S_TRAP;
            endcase
         end
         S_MEMADR: begin
            bus.alusrca = 1'b1;
            bus.alusrcb = SRCB_IMM;
            state_nxt   = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            bus.iord = 1'b1;
            if (bus.mem_ready) state_nxt = S_MEMWB;
         end
         S_MEMWR: begin
            bus.iord     = 1'b1;
            bus.memwrite = 1'b1;
            if (bus.mem_ready) begin
               bus.retire = 1'b1;
               state_nxt  = S_FETCH;
            end
         end
         S_MEMWB: begin
            bus.memtoreg = 1'b1;
            bus.regwrite = 1'b1;
            bus.retire   = 1'b1;
            state_nxt    = S_FETCH;
         end
         S_EXEC: begin
            bus.alusrca    = 1'b1;
            bus.alucontrol = aludec_ctrl;
            state_nxt      = aludec_valid ? S_ALUWB : S_TRAP;
         end
         S_ALUWB: begin
            bus.regdst   = 1'b1;
            bus.regwrite = 1'b1;
            bus.retire   = 1'b1;
            state_nxt    = S_FETCH;
         end
         S_ADDIEX, S_SLTIEX: begin
            bus.alusrca    = 1'b1;
            bus.alusrcb    = SRCB_IMM;
            bus.alucontrol = (state_q == S_SLTIEX) ? ALU_SLT : ALU_ADD;
            state_nxt      = S_IMMWB;
         end
         S_IMMWB: begin
            bus.regwrite = 1'b1;
            bus.retire   = 1'b1;
            state_nxt    = S_FETCH;
         end
         S_BRANCH: begin
            bus.alusrca    = 1'b1;
            bus.alucontrol = ALU_SUB;
            bus.pcsrc      = PCSRC_ALUOUT;
            bus.pcen       = (bus.op == OP_BEQ) ? bus.zero : ~bus.zero;
            bus.retire     = 1'b1;
            state_nxt      = S_FETCH;
         end
         S_JUMP: begin
            bus.pcsrc  = PCSRC_JUMP;
            bus.pcen   = 1'b1;
            bus.retire = 1'b1;
            state_nxt  = S_FETCH;
         end
         S_JR: begin
            bus.pcsrc  = PCSRC_REGA;
            bus.pcen   = 1'b1;
            bus.retire = 1'b1;
            state_nxt  = S_FETCH;
         end
         S_TRAP: begin
            bus.trap = 1'b1;
         end
         default: state_nxt = S_FETCH;
      endcase
      // The state register already sits in FETCH during reset, but FETCH
      // would otherwise fire irwrite/pcen on mem_ready, so gate enables here.
      if (reset) begin
         bus.pcen     = 1'b0;
         bus.irwrite  = 1'b0;
         bus.regwrite = 1'b0;
         bus.memwrite = 1'b0;
         bus.retire   = 1'b0;
      end
   end

   assign bus.state = state_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed testbench for mips_mc_ctrl.
module tb_mips_mc_ctrl;
   import mips_mc_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_tests = 0;
   int   n_fail = 0;

   mips_mc_ctrl_if bus ();

   mips_mc_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Reset pulse away from clock edges; leaves the DUT in FETCH one edge later.
   task automatic do_reset();
      bus.mem_ready = 1'b0;
      reset = 1'b1;
      #2;
      reset = 1'b0;
      next_cycle();
      bus.mem_ready = 1'b1;
   endtask

   task automatic test_reset();
      next_cycle();
      n_tests++; if (bus.state !== 4'd0) begin n_fail++; $display("FAIL rst_state: got %0d want 0", bus.state); end
      n_tests++; if (bus.pcen !== 1'b0) begin n_fail++; $display("FAIL rst_pcen: got %b want 0", bus.pcen); end
      n_tests++; if (bus.irwrite !== 1'b0) begin n_fail++; $display("FAIL rst_irwrite: got %b want 0", bus.irwrite); end
      n_tests++; if (bus.regwrite !== 1'b0) begin n_fail++; $display("FAIL rst_regwrite: got %b want 0", bus.regwrite); end
      n_tests++; if (bus.memwrite !== 1'b0) begin n_fail++; $display("FAIL rst_memwrite: got %b want 0", bus.memwrite); end
      n_tests++; if (bus.retire !== 1'b0) begin n_fail++; $display("FAIL rst_retire: got %b want 0", bus.retire); end
      n_tests++; if (bus.trap !== 1'b0) begin n_fail++; $display("FAIL rst_trap: got %b want 0", bus.trap); end
      reset = 1'b0;
      #1;
      n_tests++; if (bus.irwrite !== 1'b1) begin n_fail++; $display("FAIL fetch_irwrite: got %b want 1", bus.irwrite); end
      n_tests++; if (bus.pcen !== 1'b1) begin n_fail++; $display("FAIL fetch_pcen: got %b want 1", bus.pcen); end
      n_tests++; if (bus.alusrcb !== 2'b01) begin n_fail++; $display("FAIL fetch_alusrcb: got %b want 01", bus.alusrcb); end
      n_tests++; if (bus.alucontrol !== 3'b010) begin n_fail++; $display("FAIL fetch_aluctl: got %b want 010", bus.alucontrol); end
      bus.mem_ready = 1'b0;
      #1;
      n_tests++; if (bus.irwrite !== 1'b0) begin n_fail++; $display("FAIL fetch_wait_irwrite: got %b want 0", bus.irwrite); end
      next_cycle();
      n_tests++; if (bus.state !== 4'd0) begin n_fail++; $display("FAIL fetch_hold: got %0d want 0", bus.state); end
      bus.mem_ready = 1'b1;
   endtask

   task automatic test_lw();
      logic [3:0] exp_st [5];
      int ret_cnt = 0;
      exp_st = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB};
      bus.op = OP_LW;
      bus.mem_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         n_tests++; if (bus.state !== exp_st[i]) begin n_fail++; $display("FAIL lw_state[%0d]: got %0d want %0d", i, bus.state, exp_st[i]); end
         n_tests++; if (bus.regwrite !== 1'(i == 4)) begin n_fail++; $display("FAIL lw_regwrite[%0d]: got %b want %b", i, bus.regwrite, i == 4); end
         n_tests++; if (bus.memtoreg !== 1'(i == 4)) begin n_fail++; $display("FAIL lw_memtoreg[%0d]: got %b want %b", i, bus.memtoreg, i == 4); end
         if (i == 3) begin
            n_tests++; if (bus.iord !== 1'b1) begin n_fail++; $display("FAIL lw_iord: got %b want 1", bus.iord); end
         end
         if (bus.retire === 1'b1) ret_cnt++;
         next_cycle();
      end
      n_tests++; if (ret_cnt != 1) begin n_fail++; $display("FAIL lw_retire_count: got %0d want 1", ret_cnt); end
      n_tests++; if (bus.state !== S_FETCH) begin n_fail++; $display("FAIL lw_end_state: got %0d want %0d", bus.state, S_FETCH); end
   endtask

   task automatic test_sw_wait();
      logic [3:0] exp_st [6];
      logic       mr [6];
      exp_st = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMWR, S_MEMWR, S_MEMWR};
      mr     = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      bus.op = OP_SW;
      for (int i = 0; i < 6; i++) begin
         bus.mem_ready = mr[i];
         #1;
         n_tests++; if (bus.state !== exp_st[i]) begin n_fail++; $display("FAIL sw_state[%0d]: got %0d want %0d", i, bus.state, exp_st[i]); end
         n_tests++; if (bus.memwrite !== 1'(i >= 3)) begin n_fail++; $display("FAIL sw_memwrite[%0d]: got %b want %b", i, bus.memwrite, i >= 3); end
         n_tests++; if (bus.retire !== 1'(i == 5)) begin n_fail++; $display("FAIL sw_retire[%0d]: got %b want %b", i, bus.retire, i == 5); end
         next_cycle();
      end
      bus.mem_ready = 1'b1;
      n_tests++; if (bus.state !== S_FETCH) begin n_fail++; $display("FAIL sw_end_state: got %0d want %0d", bus.state, S_FETCH); end
   endtask

   task automatic test_branch();
      logic [5:0] ops  [4];
      logic       zs   [4];
      logic       pcen_exp [4];
      ops      = '{6'b000101, 6'b000101, 6'b000100, 6'b000100};
      zs       = '{1'b0, 1'b1, 1'b0, 1'b1};
      pcen_exp = '{1'b1, 1'b0, 1'b0, 1'b1};
      for (int k = 0; k < 4; k++) begin
         bus.op = ops[k];
         bus.zero = zs[k];
         next_cycle();
         next_cycle();
         n_tests++; if (bus.state !== S_BRANCH) begin n_fail++; $display("FAIL br_state[%0d]: got %0d want %0d", k, bus.state, S_BRANCH); end
         n_tests++; if (bus.pcen !== pcen_exp[k]) begin n_fail++; $display("FAIL br_pcen[%0d]: got %b want %b", k, bus.pcen, pcen_exp[k]); end
         n_tests++; if (bus.pcsrc !== 2'b01) begin n_fail++; $display("FAIL br_pcsrc[%0d]: got %b want 01", k, bus.pcsrc); end
         n_tests++; if (bus.alucontrol !== 3'b110) begin n_fail++; $display("FAIL br_aluctl[%0d]: got %b want 110", k, bus.alucontrol); end
         n_tests++; if (bus.retire !== 1'b1) begin n_fail++; $display("FAIL br_retire[%0d]: got %b want 1", k, bus.retire); end
         next_cycle();
      end
      bus.zero = 1'b0;
   endtask

   task automatic test_rtype();
      logic [5:0] fn  [6];
      logic [2:0] ac  [6];
      fn = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
      ac = '{3'b010,    3'b110,    3'b000,    3'b001,    3'b111,    3'b011};
      bus.op = OP_RTYPE;
      for (int k = 0; k < 6; k++) begin
         bus.funct = fn[k];
         next_cycle();
         next_cycle();
         n_tests++; if (bus.state !== S_EXEC) begin n_fail++; $display("FAIL r_exec_state[%0d]: got %0d want %0d", k, bus.state, S_EXEC); end
         n_tests++; if (bus.alucontrol !== ac[k]) begin n_fail++; $display("FAIL r_aluctl[%0d]: got %b want %b", k, bus.alucontrol, ac[k]); end
         n_tests++; if ({bus.alusrca, bus.alusrcb} !== 3'b100) begin n_fail++; $display("FAIL r_srcs[%0d]: got %b want 100", k, {bus.alusrca, bus.alusrcb}); end
         next_cycle();
         n_tests++; if ({bus.state, bus.regdst, bus.regwrite, bus.retire} !== {S_ALUWB, 3'b111}) begin
            n_fail++; $display("FAIL r_aluwb[%0d]: got %0d/%b%b%b want %0d/111", k, bus.state, bus.regdst, bus.regwrite, bus.retire, S_ALUWB);
         end
         next_cycle();
      end
   endtask

   task automatic test_imm();
      bus.op = OP_ADDI;
      next_cycle();
      next_cycle();
      n_tests++; if (bus.state !== S_ADDIEX) begin n_fail++; $display("FAIL addi_state: got %0d want %0d", bus.state, S_ADDIEX); end
      n_tests++; if ({bus.alucontrol, bus.alusrcb} !== 5'b010_10) begin n_fail++; $display("FAIL addi_alu: got %b want 01010", {bus.alucontrol, bus.alusrcb}); end
      next_cycle();
      n_tests++; if ({bus.state, bus.regdst, bus.regwrite, bus.retire} !== {S_IMMWB, 3'b011}) begin n_fail++; $display("FAIL addi_wb: got %0d/%b%b%b", bus.state, bus.regdst, bus.regwrite, bus.retire); end
      next_cycle();
      bus.op = OP_SLTI;
      next_cycle();
      next_cycle();
      n_tests++; if (bus.state !== S_SLTIEX) begin n_fail++; $display("FAIL slti_state: got %0d want %0d", bus.state, S_SLTIEX); end
      n_tests++; if ({bus.alucontrol, bus.alusrcb} !== 5'b111_10) begin n_fail++; $display("FAIL slti_alu: got %b want 11110", {bus.alucontrol, bus.alusrcb}); end
      next_cycle();
      n_tests++; if (bus.state !== S_IMMWB) begin n_fail++; $display("FAIL slti_wb: got %0d want %0d", bus.state, S_IMMWB); end
      next_cycle();
      n_tests++; if (bus.state !== S_FETCH) begin n_fail++; $display("FAIL slti_end: got %0d want %0d", bus.state, S_FETCH); end
   endtask

   task automatic test_jumps();
      bus.op = OP_J;
      next_cycle();
      next_cycle();
      n_tests++; if ({bus.state, bus.pcsrc, bus.pcen} !== {S_JUMP, 3'b101}) begin n_fail++; $display("FAIL j: got %0d/%b/%b want %0d/10/1", bus.state, bus.pcsrc, bus.pcen, S_JUMP); end
      next_cycle();
      bus.op = OP_RTYPE;
      bus.funct = 6'b001000;
      next_cycle();
      n_tests++; if (bus.state !== S_DECODE) begin n_fail++; $display("FAIL jr_decode: got %0d want %0d", bus.state, S_DECODE); end
      next_cycle();
      n_tests++; if ({bus.state, bus.pcsrc, bus.pcen} !== {S_JR, 3'b111}) begin n_fail++; $display("FAIL jr: got %0d/%b/%b want %0d/11/1", bus.state, bus.pcsrc, bus.pcen, S_JR); end
      n_tests++; if (bus.retire !== 1'b1) begin n_fail++; $display("FAIL jr_retire: got %b want 1", bus.retire); end
      next_cycle();
      n_tests++; if (bus.state !== S_FETCH) begin n_fail++; $display("FAIL jr_end: got %0d want %0d", bus.state, S_FETCH); end
   endtask

   task automatic test_trap();
      bus.op = OP_RTYPE;
      bus.funct = 6'b100111;
      next_cycle();
      next_cycle();
      next_cycle();
      for (int i = 0; i < 12; i++) begin
         n_tests++; if ({bus.state, bus.trap} !== {S_TRAP, 1'b1}) begin n_fail++; $display("FAIL trap_hold[%0d]: got %0d/%b want %0d/1", i, bus.state, bus.trap, S_TRAP); end
         n_tests++; if ({bus.pcen, bus.irwrite, bus.regwrite, bus.memwrite, bus.retire} !== 5'b0) begin n_fail++; $display("FAIL trap_enables[%0d]: got %b want 00000", i, {bus.pcen, bus.irwrite, bus.regwrite, bus.memwrite, bus.retire}); end
         next_cycle();
      end
      do_reset();
      n_tests++; if ({bus.state, bus.trap} !== 5'b0) begin n_fail++; $display("FAIL trap_clear: got %0d/%b want 0/0", bus.state, bus.trap); end
      bus.op = 6'b111111;
      next_cycle();
      next_cycle();
      n_tests++; if ({bus.state, bus.trap} !== {S_TRAP, 1'b1}) begin n_fail++; $display("FAIL bad_op_trap: got %0d/%b want %0d/1", bus.state, bus.trap, S_TRAP); end
      do_reset();
   endtask

   task automatic test_reset_midmem();
      bus.op = OP_LW;
      bus.mem_ready = 1'b1;
      next_cycle();
      next_cycle();
      bus.mem_ready = 1'b0;
      next_cycle();
      n_tests++; if (bus.state !== S_MEMRD) begin n_fail++; $display("FAIL mid_memrd: got %0d want %0d", bus.state, S_MEMRD); end
      next_cycle();
      #2;
      bus.mem_ready = 1'b1;
      reset = 1'b1;
      #1;
      n_tests++; if (bus.state !== 4'd0) begin n_fail++; $display("FAIL mid_async_state: got %0d want 0", bus.state); end
      n_tests++; if ({bus.regwrite, bus.pcen, bus.irwrite, bus.trap} !== 4'b0) begin n_fail++; $display("FAIL mid_rst_outs: got %b want 0000", {bus.regwrite, bus.pcen, bus.irwrite, bus.trap}); end
      next_cycle();
      n_tests++; if ({bus.state, bus.irwrite, bus.pcen} !== 6'b0) begin n_fail++; $display("FAIL mid_rst_hold: got %0d/%b%b want 0/00", bus.state, bus.irwrite, bus.pcen); end
      bus.mem_ready = 1'b0;
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         n_tests++; if ({bus.state, bus.regwrite, bus.memwrite} !== 6'b0) begin n_fail++; $display("FAIL mid_after[%0d]: got %0d/%b%b want 0/00", i, bus.state, bus.regwrite, bus.memwrite); end
      end
      bus.op = OP_J;
      bus.mem_ready = 1'b1;
      next_cycle();
      next_cycle();
      next_cycle();
   endtask

   initial begin
      bus.op = 6'b0;
      bus.funct = 6'b0;
      bus.zero = 1'b0;
      bus.mem_ready = 1'b1;
      test_reset();
      test_lw();
      test_sw_wait();
      test_branch();
      test_rtype();
      test_imm();
      test_jumps();
      test_trap();
      test_reset_midmem();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
